// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: two requester handshakes, the registered register-file
// write and the debug counters. The slave modport is the arbiter side.
interface wb_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              m0_valid_i, m0_ready_o;
  logic [ADDR_W-1:0] m0_waddr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m1_valid_i, m1_ready_o;
  logic [ADDR_W-1:0] m1_waddr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              last_grant_o;
  logic [CNT_W-1:0]  m0_stall_cnt_o, m1_stall_cnt_o;

  modport slave (
    input  m0_valid_i, m0_waddr_i, m0_wdata_i, m1_valid_i, m1_waddr_i, m1_wdata_i,
    output m0_ready_o, m1_ready_o, we_o, waddr_o, wdata_o, last_grant_o,
           m0_stall_cnt_o, m1_stall_cnt_o
  );
  modport master (
    output m0_valid_i, m0_waddr_i, m0_wdata_i, m1_valid_i, m1_waddr_i, m1_wdata_i,
    input  m0_ready_o, m1_ready_o, we_o, waddr_o, wdata_o, last_grant_o,
           m0_stall_cnt_o, m1_stall_cnt_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file writeback arbiter with a one-stage registered write.
// Round-robin by default; WB_ARB_FIXED_PRIO_EN selects fixed priority m1 > m0.
module wb_arb_stall_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

module wb_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]             vld, gnt;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] data;
  logic [NUM_REQ-1:0][CNT_W-1:0]  cnt;
  logic                           sel;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_grant_q, last_grant_d;

  assign vld  = {bus.m1_valid_i, bus.m0_valid_i};
  assign addr = {bus.m1_waddr_i, bus.m0_waddr_i};
  assign data = {bus.m1_wdata_i, bus.m0_wdata_i};

  always_comb begin
    gnt = vld;
`ifdef WB_ARB_FIXED_PRIO_EN
    if (&vld) gnt = 2'b10;
`else
    // On contention the requester that did not win last time goes next
    if (&vld) gnt = last_grant_q ? 2'b01 : 2'b10;
`endif
  end

  assign sel = gnt[1];

  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    if (|gnt) begin
      last_grant_d = sel;
      // x0 is hardwired: accept the handshake but never write it
      if (addr[sel] != '0) begin
        we_d    = 1'b1;
        waddr_d = addr[sel];
        wdata_d = data[sel];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stall
    wb_arb_stall_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (vld[g] & ~gnt[g]),
      .cnt_o (cnt[g])
    );
  end

  assign bus.m0_ready_o     = gnt[0];
  assign bus.m1_ready_o     = gnt[1];
  assign bus.we_o           = we_q;
  assign bus.waddr_o        = waddr_q;
  assign bus.wdata_o        = wdata_q;
  assign bus.last_grant_o   = last_grant_q;
  assign bus.m0_stall_cnt_o = cnt[0];
  assign bus.m1_stall_cnt_o = cnt[1];
endmodule
